seg_score_capture: RTL and testbench
====================================

Name: seg_score_capture

Overview:
Receiver end of the multiplexed two-digit seven-segment score bus: seg_a..seg_g plus the cath digit-select, which toggles every clk.
- Synchronises and demultiplexes the bus by cath phase.
- Decodes each digit slot back to a 4-bit score after a stability filter.
- Detects the game-over blink (blanked digits).
- Used in-design as a self-check/loopback monitor and by the top-level bench to read displayed scores.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchroniser on {seg_g..seg_a, cath} (min 1)
STABLE_N, 3, consecutive identical samples of a slot required before a pattern is accepted (min 1)
BLINK_TIMEOUT, 2048, cycles without an accepted blank before game_over clears

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
seg_a..seg_g  in  1 each  segment lines, active-high, bit order {g,f,e,d,c,b,a}
cath  in  1  digit select: 0 = player 1 slot, 1 = player 2 slot
score_p1  out  4  last accepted player-1 digit
score_p2  out  4  last accepted player-2 digit
valid_p1  out  1  score_p1 holds an accepted value since reset
valid_p2  out  1  score_p2 holds an accepted value since reset
game_over  out  1  blanking (blink) detected, held until timeout
seg_err  out  1  sticky: an accepted pattern was neither a hex glyph nor blank
phase_err  out  1  one-cycle pulse: sampled cath equal to previous sampled cath

Behaviour:
- Reset values:
  - All outputs 0.
  - Synchroniser flops, last-pattern registers, stability counters, timeout counter and previous-cath register all 0.
- Synchroniser: all 8 inputs pass through SYNC_STAGES flops. All logic below uses the synchronised values (s_seg, s_cath).
- Slot select: s_cath=0 updates only slot 1 state; s_cath=1 updates only slot 2 state. Each slot sees a sample every 2 cycles in normal operation.
- Pattern classes, from decoder sub-module:
  - Glyph: one of the 16 hex glyphs 0..F, standard a..g encoding (0=0111111, 1=0000110, 8=1111111, 9=1101111, A=1110111, F=1110001).
  - Blank: 0000000.
  - Invalid: anything else.
- Stability filter, per slot:
  - If the sample equals the slot's last pattern, the counter increments, saturating at STABLE_N.
  - Otherwise last pattern is loaded and the counter is set to 1.
  - A pattern is accepted on the sample where the counter becomes STABLE_N. This happens exactly once per run and also when STABLE_N=1.
- On acceptance:
  - Glyph: score_pX loads the value; valid_pX is set.
  - Blank: score and valid hold; game_over is set and the timeout counter clears.
  - Invalid: score holds; seg_err is set (sticky until reset).
- Latency: a glyph driven on the pins from cycle t in its slot phase is visible on score_pX at cycle t + SYNC_STAGES + 2*(STABLE_N-1) + 1. Defaults give t+7.
- game_over clear:
  - Timeout counter increments each cycle while game_over=1, saturating.
  - When it reaches BLINK_TIMEOUT-1 without an intervening accepted blank, game_over clears next cycle.
  - A blank accepted in the same cycle as the timeout wins: game_over stays 1 and the counter restarts at 0.
- phase_err: asserted for one cycle when s_cath equals the previous s_cath. Suppressed for the first cycle after reset, and for SYNC_STAGES cycles after reset so synchroniser fill is not flagged. Slot processing is unaffected by phase_err (a slot may be sampled on consecutive cycles).
- Reset mid-run: every register returns to its reset value on the next edge. In-flight filter runs are discarded.
- Widths: stability counters are clog2(STABLE_N+1) bits; timeout counter is clog2(BLINK_TIMEOUT) bits. No wrap: both saturate.

Decomposition:
- Shared package pong_pkg:
  - SEG_GLYPH[0:15] 7-bit constants and SEG_BLANK = 7'b0.
  - The display driver's encode table moves here so encoder and decoder share one source.
- Sub-module seg7_decode (combinational): 7-bit pattern in; out is_glyph, is_blank, value[3:0]. Implemented by compare against pong_pkg constants.
- Instantiated once, on s_seg. Only one slot is processed per cycle.

Test Plan:
- Alternate cath each cycle; slot 1 = glyph 3 (1001111), slot 2 = glyph 7 (0000111) from cycle 10 -> score_p1=3 at cycle 17, score_p2=7 at cycle 18, valid_p1/valid_p2 set; game_over, seg_err, phase_err stay 0.
- Slot 1 glitches 3→8→3, each held for one slot sample, then 3 stable -> score_p1 never shows 8; 3 is accepted only after 3 consecutive samples.
- Score 9 / 4, then both slots blank for 512 cycles and lit for 512, repeated -> game_over rises 7 cycles after the first blank; scores hold 9/4 throughout; game_over stays 1. Stop blinking -> game_over clears BLINK_TIMEOUT cycles after the last accepted blank.
- Slot 2 driven with 1010101 (invalid) stably -> seg_err=1 and stays 1; score_p2 is unchanged.
- Hold cath=1 for 2 cycles mid-stream -> exactly one phase_err pulse, SYNC_STAGES cycles later; decoding resumes correctly.
- Assert reset for 1 cycle while score_p1=5 and game_over=1 -> all outputs 0 on the next cycle; rediscovery latency is again 7 cycles.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared seven-segment encoding for the score display driver and its capture monitor.
// Contents: seg_bus_t (one sampled bus word), SEG_GLYPH hex table, SEG_BLANK, seg_encode().
package pong_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;

    // One sample of the multiplexed score bus: digit select plus {g,f,e,d,c,b,a}.
    typedef struct packed {
        logic             cath;
        logic [SEG_W-1:0] seg;
    } seg_bus_t;

    // Active-high segments, bit order {g,f,e,d,c,b,a}, glyphs 0..F.
    localparam logic [SEG_W-1:0] SEG_GLYPH [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Encoder side of the shared table.
    function automatic logic [SEG_W-1:0] seg_encode(input logic [DIGIT_W-1:0] digit);
        return SEG_GLYPH[digit];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern classifier.
// Ports: pattern (in, {g..a}); is_glyph, is_blank, value[3:0] (out).
module seg7_decode
    import pong_pkg::*;
(
    input  logic [SEG_W-1:0]   pattern,
    output logic               is_glyph,
    output logic               is_blank,
    output logic [DIGIT_W-1:0] value
);

    // Match against the shared glyph table; value is 0 when no glyph matches.
    always_comb begin
        is_glyph = 1'b0;
        value    = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (pattern == SEG_GLYPH[i]) begin
                is_glyph = 1'b1;
                value    = DIGIT_W'(i);
            end
        end
        is_blank = (pattern == SEG_BLANK);
    end

endmodule

// File: rtl/seg_score_capture.sv
// Receiver of the multiplexed two-digit seven-segment score bus.
// Synchronises the bus, demultiplexes it by cath phase, filters each slot for
// stability, and reports decoded scores, game-over blinking and bus errors.
// Ports: clk, reset (sync, active-high), seg_a..seg_g, cath (in);
//        score_p1/p2[3:0], valid_p1/p2, game_over, seg_err, phase_err (out, registered).
module seg_score_capture
    import pong_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_N      = 3,
    parameter int unsigned BLINK_TIMEOUT = 2048
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               seg_a,
    input  logic               seg_b,
    input  logic               seg_c,
    input  logic               seg_d,
    input  logic               seg_e,
    input  logic               seg_f,
    input  logic               seg_g,
    input  logic               cath,
    output logic [DIGIT_W-1:0] score_p1,
    output logic [DIGIT_W-1:0] score_p2,
    output logic               valid_p1,
    output logic               valid_p2,
    output logic               game_over,
    output logic               seg_err,
    output logic               phase_err
);

    localparam int unsigned CNT_W = $clog2(STABLE_N + 1);
    localparam int unsigned TO_W  = (BLINK_TIMEOUT > 2) ? $clog2(BLINK_TIMEOUT) : 1;
    localparam int unsigned SUP_W = $clog2(SYNC_STAGES + 2);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_N);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BLINK_TIMEOUT - 1);
    localparam logic [SUP_W-1:0] SUP_DONE = SUP_W'(SYNC_STAGES + 1);

    seg_bus_t bus_in;
    seg_bus_t s_bus;
    seg_bus_t sync_q [SYNC_STAGES];

    logic [SEG_W-1:0] last_q [2];
    logic [CNT_W-1:0] cnt_q  [2];
    logic [TO_W-1:0]  to_cnt_q;
    logic [SUP_W-1:0] sup_cnt_q;
    logic             prev_cath_q;

    logic               slot;
    logic [SEG_W-1:0]   cur_last;
    logic [CNT_W-1:0]   cur_cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               match;
    logic               accept;
    logic               dec_glyph;
    logic               dec_blank;
    logic [DIGIT_W-1:0] dec_value;

    always_comb begin
        bus_in.cath = cath;
        bus_in.seg  = {seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a};
    end

    assign s_bus = sync_q[SYNC_STAGES-1];
    assign slot  = s_bus.cath;

    // Single decoder on the synchronised bus; only the active slot uses it.
    seg7_decode u_decode (
        .pattern  (s_bus.seg),
        .is_glyph (dec_glyph),
        .is_blank (dec_blank),
        .value    (dec_value)
    );

    // Stability filter for the slot selected this cycle; accept fires once per run.
    always_comb begin
        cur_last = last_q[slot];
        cur_cnt  = cnt_q[slot];
        match    = (s_bus.seg == cur_last);
        if (!match) begin
            cnt_nxt = CNT_W'(1);
        end else if (cur_cnt == CNT_MAX) begin
            cnt_nxt = cur_cnt;
        end else begin
            cnt_nxt = cur_cnt + CNT_W'(1);
        end
        accept = (cnt_nxt == CNT_MAX) && !(match && (cur_cnt == CNT_MAX));
    end

    // Synchroniser chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Slot state, score/flag outputs, blink timeout and phase checking.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q[0]   <= '0;
            last_q[1]   <= '0;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
            to_cnt_q    <= '0;
            sup_cnt_q   <= '0;
            prev_cath_q <= 1'b0;
            score_p1    <= '0;
            score_p2    <= '0;
            valid_p1    <= 1'b0;
            valid_p2    <= 1'b0;
            game_over   <= 1'b0;
            seg_err     <= 1'b0;
            phase_err   <= 1'b0;
        end else begin
            last_q[slot] <= s_bus.seg;
            cnt_q[slot]  <= cnt_nxt;
            prev_cath_q  <= s_bus.cath;

            if (accept && dec_glyph) begin
                if (slot) begin
                    score_p2 <= dec_value;
                    valid_p2 <= 1'b1;
                end else begin
                    score_p1 <= dec_value;
                    valid_p1 <= 1'b1;
                end
            end

            if (accept && !dec_glyph && !dec_blank) begin
                seg_err <= 1'b1;
            end

            // An accepted blank beats the timeout expiring in the same cycle.
            if (accept && dec_blank) begin
                game_over <= 1'b1;
                to_cnt_q  <= '0;
            end else if (game_over) begin
                if (to_cnt_q == TO_LAST) begin
                    game_over <= 1'b0;
                end else begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                end
            end

            // Hold off until both current and previous s_cath carry real pin data.
            if (sup_cnt_q != SUP_DONE) begin
                sup_cnt_q <= sup_cnt_q + SUP_W'(1);
            end
            phase_err <= (sup_cnt_q == SUP_DONE) && (s_bus.cath == prev_cath_q);
        end
    end

endmodule

// File: tb/tb_seg_score_capture.sv
// Bench for seg_score_capture: vector table, directed latency/blink/phase/reset
// sequences and randomized traffic, all checked every cycle against a run-length model.
module tb_seg_score_capture;

    localparam int S  = 2;
    localparam int N  = 3;
    localparam int BT = 2048;

    localparam logic [6:0] G2 = 7'h5B;
    localparam logic [6:0] G3 = 7'h4F;
    localparam logic [6:0] G4 = 7'h66;
    localparam logic [6:0] G5 = 7'h6D;
    localparam logic [6:0] G6 = 7'h7D;
    localparam logic [6:0] G7 = 7'h07;
    localparam logic [6:0] G8 = 7'h7F;
    localparam logic [6:0] G9 = 7'h6F;
    localparam logic [6:0] G1 = 7'h06;

    logic       clk;
    logic       reset;
    logic [6:0] seg_pins;
    logic       cath_pin;
    logic [3:0] score_p1, score_p2;
    logic       valid_p1, valid_p2, game_over, seg_err, phase_err;

    int checks   = 0;
    int failures = 0;
    int tc       = 0;

    logic [6:0] glyph [16];

    // Reference model state: edges since reset, captured pin history, per-slot runs.
    int         k;
    logic [7:0] hist [$];
    logic [6:0] run_pat [2];
    int         run_len [2];
    logic [3:0] m_score [2];
    logic       m_valid [2];
    logic       m_err;
    logic       m_phase;
    int         last_blank;

    typedef struct {
        logic [6:0] pat;
        logic [3:0] exp_score;
        logic       exp_valid;
        logic       exp_err;
        logic       exp_go;
    } vec_t;

    vec_t vecs [18];

    seg_score_capture #(
        .SYNC_STAGES   (S),
        .STABLE_N      (N),
        .BLINK_TIMEOUT (BT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_a     (seg_pins[0]),
        .seg_b     (seg_pins[1]),
        .seg_c     (seg_pins[2]),
        .seg_d     (seg_pins[3]),
        .seg_e     (seg_pins[4]),
        .seg_f     (seg_pins[5]),
        .seg_g     (seg_pins[6]),
        .cath      (cath_pin),
        .score_p1  (score_p1),
        .score_p2  (score_p2),
        .valid_p1  (valid_p1),
        .valid_p2  (valid_p2),
        .game_over (game_over),
        .seg_err   (seg_err),
        .phase_err (phase_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int glyph_index(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (p == glyph[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at tick %0d: got %0h expected %0h", name, tc, got, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        hist.delete();
        for (int i = 0; i < 2; i++) begin
            run_pat[i] = 7'h00;
            run_len[i] = 0;
            m_score[i] = 4'h0;
            m_valid[i] = 1'b0;
        end
        m_err      = 1'b0;
        m_phase    = 1'b0;
        last_blank = -1;
    endtask

    // A slot pattern is accepted when its run of identical samples reaches N.
    task automatic model_edge(input logic [7:0] pins);
        logic [7:0] s, sp;
        int slot, gi;
        k++;
        hist.push_back(pins);
        s  = (k > S)     ? hist[k-S-1] : 8'h00;
        sp = (k - 1 > S) ? hist[k-S-2] : 8'h00;
        m_phase = (k >= S + 2) && (s[7] == sp[7]);
        slot = int'(s[7]);
        if (run_len[slot] > 0 && s[6:0] == run_pat[slot]) begin
            run_len[slot]++;
        end else begin
            run_pat[slot] = s[6:0];
            run_len[slot] = 1;
        end
        if (run_len[slot] == N) begin
            gi = glyph_index(s[6:0]);
            if (gi >= 0) begin
                m_score[slot] = 4'(gi);
                m_valid[slot] = 1'b1;
            end else if (s[6:0] == 7'h00) begin
                last_blank = k;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic m_go;
        m_go = (last_blank >= 0) && (k - last_blank < BT);
        check("cycle",
              {19'd0, valid_p2, valid_p1, score_p2, score_p1, game_over, seg_err, phase_err},
              {19'd0, m_valid[1], m_valid[0], m_score[1], m_score[0], m_go, m_err, m_phase});
    endtask

    task automatic tick(input logic [6:0] seg, input logic c);
        seg_pins = seg;
        cath_pin = c;
        @(posedge clk);
        model_edge({c, seg});
        tc++;
        #1;
        check_all();
    endtask

    // Normal alternation: odd ticks since reset drive slot 1, even ticks slot 2.
    task automatic tick2(input logic [6:0] p1, input logic [6:0] p2);
        if ((tc + 1) % 2 == 0) tick(p2, 1'b1);
        else                   tick(p1, 1'b0);
    endtask

    task automatic reset_tick();
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        tc = 0;
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        logic [6:0] gseq [8];
        logic [6:0] rp [2];
        int         hold [2];
        int         pulses, pulse_at, bad, go_low;
        logic       c;

        reset    = 1'b1;
        seg_pins = 7'h00;
        cath_pin = 1'b0;
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        for (int i = 0; i < 16; i++) vecs[i] = '{glyph[i], 4'(i), 1'b1, 1'b0, 1'b0};
        vecs[16] = '{7'h00, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{7'h55, 4'h0, 1'b0, 1'b1, 1'b0};

        // Vector table: slot 1 driven steadily, slot 2 shows glyph 0.
        for (int i = 0; i < 18; i++) begin
            reset_tick();
            repeat (12) tick2(vecs[i].pat, glyph[0]);
            check($sformatf("vec%0d", i),
                  {valid_p1, score_p1, seg_err, game_over},
                  {vecs[i].exp_valid, vecs[i].exp_score, vecs[i].exp_err, vecs[i].exp_go});
        end

        // First-acceptance latency: 3 / 7.
        reset_tick();
        for (int n = 1; n <= 20; n++) begin
            tick2(G3, G7);
            if (n == 6) check("lat_p1_early", {valid_p1, score_p1}, 5'h00);
            if (n == 7) begin
                check("lat_p1", {valid_p1, score_p1}, 5'h13);
                check("lat_p2_early", valid_p2, 0);
            end
            if (n == 8) check("lat_p2", {valid_p2, score_p2}, 5'h17);
        end
        check("lat_flags", {game_over, seg_err, phase_err}, 0);

        // Glitch 3 -> 8 -> 3 on slot 1; 8 must never be shown.
        gseq = '{G3, G8, G3, G3, G3, G3, G3, G3};
        reset_tick();
        bad = 0;
        for (int n = 1; n <= 16; n++) begin
            tick2(gseq[(n - 1) / 2], G7);
            if (score_p1 == 4'd8) bad++;
            if (n == 10) check("glitch_early", valid_p1, 0);
            if (n == 11) check("glitch_accept", {valid_p1, score_p1}, 5'h13);
        end
        check("glitch_no8", bad, 0);

        // Blink blank/lit, then stop and wait for the timeout.
        reset_tick();
        repeat (20) tick2(G9, G4);
        bad = 0;
        go_low = 0;
        while (tc < 1556) begin
            if (tc < 532 || tc >= 1044) tick2(7'h00, 7'h00);
            else                        tick2(G9, G4);
            if (tc == 26) check("blink_rise_early", game_over, 0);
            if (tc == 27) check("blink_rise", game_over, 1);
            if (tc >= 27 && !game_over) go_low++;
            if ({score_p2, score_p1} != 8'h49) bad++;
        end
        check("blink_scores", bad, 0);
        check("blink_go_held", go_low, 0);
        while (tc < 3105) begin
            tick2(G9, G4);
            if (tc == 1052 + BT - 1) check("timeout_hold", game_over, 1);
            if (tc == 1052 + BT)     check("timeout_clear", game_over, 0);
        end

        // Invalid pattern on slot 2.
        reset_tick();
        repeat (20) tick2(G2, G5);
        repeat (20) tick2(G2, 7'h55);
        check("inv_err", {seg_err, score_p2}, 5'h15);
        repeat (10) tick2(G2, G5);
        check("inv_sticky", {seg_err, score_p2}, 5'h15);

        // cath held high for two cycles.
        reset_tick();
        repeat (20) tick2(G1, G6);
        pulses = 0;
        pulse_at = -1;
        tick(G6, 1'b1);
        if (phase_err) begin pulses++; pulse_at = tc; end
        for (int n = 22; n <= 32; n++) begin
            if (n % 2 == 1) tick(G6, 1'b1);
            else            tick(G1, 1'b0);
            if (phase_err) begin pulses++; pulse_at = tc; end
        end
        check("phase_pulses", pulses, 1);
        check("phase_when", pulse_at, 21 + S);
        for (int n = 33; n <= 46; n++) begin
            if (n % 2 == 1) tick(G8, 1'b1);
            else            tick(G2, 1'b0);
        end
        check("phase_resume", {score_p2, score_p1}, 8'h82);

        // Reset in the middle of a game-over blink.
        reset_tick();
        repeat (16) tick2(G5, 7'h00);
        check("mid_pre", {game_over, score_p1}, 5'h15);
        reset_tick();
        check("mid_zero", {valid_p2, valid_p1, score_p2, score_p1, game_over, seg_err, phase_err}, 0);
        for (int n = 1; n <= 8; n++) begin
            tick2(G5, G3);
            if (n == 6) check("mid_early", valid_p1, 0);
            if (n == 7) check("mid_relatch", {valid_p1, score_p1}, 5'h15);
        end

        // Randomized traffic with occasional phase slips and resets.
        reset_tick();
        c = 1'b1;
        for (int i = 0; i < 2; i++) begin rp[i] = glyph[i]; hold[i] = 0; end
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 999) < 3) begin
                reset_tick();
            end else begin
                if ($urandom_range(0, 99) >= 3) c = ~c;
                if (hold[int'(c)] == 0) begin
                    int r;
                    r = $urandom_range(0, 99);
                    if (r < 80)      rp[int'(c)] = glyph[$urandom_range(0, 15)];
                    else if (r < 85) rp[int'(c)] = 7'h00;
                    else             rp[int'(c)] = 7'($urandom);
                    hold[int'(c)] = $urandom_range(1, 8);
                end
                hold[int'(c)]--;
                tick(rp[int'(c)], c);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
